muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter ACC_ADDR, default 8'hE0, SFR address of ACC.
REQ-002 SHALL have parameter B_ADDR, default 8'hF0, SFR address of B.
REQ-003 SHALL have port: clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous active-low reset (0 = reset).
REQ-005 SHALL have port: start  input  1  request one MUL AB / DIV AB operation.
REQ-006 SHALL have port: op  input  1  operation select: 0 = MUL, 1 = DIV.
REQ-007 SHALL have port: acc_in  input  8  ACC operand.
REQ-008 SHALL have port: b_in  input  8  B operand.
REQ-009 SHALL have port: wr_gnt  input  1  grant from shared SFR write port.
REQ-010 SHALL have port: busy  output  1  operation in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: wr_en  output  1  SFR write request (byte write).
REQ-013 SHALL have port: wr_bit_en  output  1  tied 0 (never bit-addressed).
REQ-014 SHALL have port: addr  output  8  SFR write address.
REQ-015 SHALL have port: data_out  output  8  SFR write data.
REQ-016 SHALL have port: ov  output  1  OV flag result.
REQ-017 SHALL have port: cy  output  1  CY flag result, always cleared.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, WR_ACC, WR_B, DONE.
REQ-019 In IDLE, start=1 SHALL sample op, acc_in and b_in on that edge and enter CALC, or enter DONE directly if op=1 and b_in=0.
REQ-020 In IDLE with start=0, no operation SHALL be accepted; start outside IDLE SHALL be ignored.
REQ-021 CALC SHALL last exactly 8 cycles, counted by a 3-bit iteration counter.
REQ-022 MUL SHALL use iterative shift-add, one multiplier bit per cycle, to form a 16-bit product.
REQ-023 DIV SHALL use restoring division, one quotient bit per cycle, to form an 8-bit quotient and 8-bit remainder.
REQ-024 After CALC, the FSM SHALL enter WR_ACC.
REQ-025 In WR_ACC: wr_en=1, addr=ACC_ADDR, data_out = product[7:0] (MUL) or quotient (DIV); advance to WR_B on the cycle wr_gnt=1.
REQ-026 In WR_B: wr_en=1, addr=B_ADDR, data_out = product[15:8] (MUL) or remainder (DIV); advance to DONE on the cycle wr_gnt=1.
REQ-027 While wr_gnt=0, addr, data_out and wr_en SHALL hold stable, with no timeout.
REQ-028 Outside WR_ACC and WR_B: wr_en=0, addr=0, data_out=0.
REQ-029 DONE SHALL last one cycle with done=1, update ov/cy, then return to IDLE.
REQ-030 MUL: ov=1 iff product[15:8]!=0; DIV: ov=0 except divide-by-zero; cy=0 always.
REQ-031 Divide-by-zero SHALL issue no SFR writes, set ov=1, and assert done on the cycle after start.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 ov and cy SHALL hold their values until the next DONE.
REQ-034 Nominal latency with wr_gnt tied 1: start edge at cycle 0, CALC in cycles 1-8, WR_ACC in cycle 9, WR_B in cycle 10, done in cycle 11.
REQ-035 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only from IDLE.

Reset
REQ-036 reset=0 SHALL asynchronously force IDLE, counter=0, and busy, done, wr_en, wr_bit_en, addr, data_out, ov, cy all 0.
REQ-037 Reset mid-operation (any state) SHALL abort with no further SFR write; a partially granted sequence (ACC written, B not) is not completed.
REQ-038 After reset release, the first start SHALL be accepted no earlier than the first rising edge with reset=1.

Structure
REQ-039 SFR address constants (SFR_ACC, SFR_B) and FSM state encoding SHALL live in the shared define_opcodes package/include; parameter defaults SHALL reference them.
REQ-040 The shift-add/restoring datapath SHALL be one sub-module, muldiv_dp (start/step/op in, product/quotient/remainder out); muldiv_seq holds the FSM, counter and write handshake.

Verification
REQ-041 MUL 8'h0C x 8'h0D, wr_gnt=1 -> ACC write 8'h9C, then B write 8'h00, ov=0, cy=0, done at cycle 11.
REQ-042 MUL 8'hFF x 8'hFF -> ACC write 8'h01, B write 8'hFE, ov=1.
REQ-043 DIV 8'hFB / 8'h12 -> ACC write 8'h0D, B write 8'h11, ov=0.
REQ-044 DIV 8'h55 / 8'h00 -> no wr_en pulse, ov=1, done at cycle 1, busy high for 1 cycle.
REQ-045 wr_gnt held 0 for 3 cycles in WR_ACC -> addr=8'hE0 and data stable all 4 cycles; done delayed by 3 cycles.
REQ-046 reset=0 at cycle 5 of CALC -> all outputs 0 immediately, no SFR write, next start completes normally.

Source files
------------

// File: rtl/define_opcodes_pkg.sv
// Shared constants for the MUL AB / DIV AB sequencer: SFR addresses,
// operation encoding and FSM state encoding.
package define_opcodes;

    // SFR byte addresses written back by MUL AB / DIV AB
    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;

    // Operation select encoding on the op input
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Last iteration index of the 8-cycle calculation phase
    localparam logic [2:0] CALC_LAST = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        WR_ACC = 3'd2,
        WR_B   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Iterative 8x8 datapath: shift-add multiply (16-bit product) or restoring
// divide (8-bit quotient and remainder), one bit per step.
// A single 16-bit work register serves both: for MUL it holds the partial
// product with the multiplier shifting out of the low byte; for DIV the high
// byte is the running remainder and the low byte shifts dividend bits out
// while quotient bits shift in.
module muldiv_dp
    import define_opcodes::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic        op,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic [15:0] product,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder
);

    logic [15:0] work;
    logic [15:0] work_next;
    logic [7:0]  opnd;       // multiplicand (MUL) or divisor (DIV)
    logic [8:0]  mul_sum;
    logic [8:0]  div_shift;
    logic [9:0]  div_diff;

    // One iteration of the selected algorithm
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        work_next = work;
        mul_sum   = {1'b0, work[15:8]} + (work[0] ? {1'b0, opnd} : 9'd0);
        div_shift = {work[15:8], work[7]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        if (op == OP_MUL) begin
            work_next = {mul_sum, work[7:1]};
        end else if (!div_diff[9]) begin
            // Trial subtraction fits: keep difference, quotient bit 1
            work_next = {div_diff[7:0], work[6:0], 1'b1};
        end else begin
            // Restore: keep shifted remainder, quotient bit 0
            work_next = {div_shift[7:0], work[6:0], 1'b0};
        end
    end

    // Operand load on start, one iteration per step
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            work <= '0;
            opnd <= '0;
        end else if (start) begin
            work <= (op == OP_DIV) ? {8'h00, a_in} : {8'h00, b_in};
            opnd <= (op == OP_DIV) ? b_in : a_in;
        end else if (step) begin
            work <= work_next;
        end
    end

    assign product   = work;
    assign quotient  = work[7:0];
    assign remainder = work[15:8];

endmodule

// File: rtl/muldiv_seq.sv
// MUL AB / DIV AB sequencer: accepts a request in IDLE, runs the iterative
// datapath for 8 cycles, writes ACC then B through the shared SFR write port
// (waiting on wr_gnt for each byte), then pulses done and updates OV/CY.
// Divide-by-zero skips the calculation and both writes.
module muldiv_seq
    import define_opcodes::*;
#(
    parameter logic [7:0] ACC_ADDR = SFR_ACC,
    parameter logic [7:0] B_ADDR   = SFR_B
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] acc_in,
    input  logic [7:0] b_in,
    input  logic       wr_gnt,
    output logic       busy,
    output logic       done,
    output logic       wr_en,
    output logic       wr_bit_en,
    output logic [7:0] addr,
    output logic [7:0] data_out,
    output logic       ov,
    output logic       cy
);

    state_t      state;
    state_t      state_next;
    logic [2:0]  iter_cnt;
    logic        op_q;
    logic        accept;
    logic        div_zero;
    logic        dp_start;
    logic        dp_step;
    logic        dp_op;
    logic [15:0] product;
    logic [7:0]  quotient;
    logic [7:0]  remainder;

    assign accept   = (state == IDLE) && start;
    assign div_zero = (op == OP_DIV) && (b_in == 8'h00);
    // The datapath sees the live op while loading, the captured op afterwards
    assign dp_op    = (state == IDLE) ? op : op_q;

    // Next-state logic and datapath control
    always_comb begin
        state_next = state;
        dp_start   = 1'b0;
        dp_step    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (div_zero) begin
                        state_next = DONE;
                    end else begin
                        state_next = CALC;
                        dp_start   = 1'b1;
                    end
                end
            end
            CALC: begin
                dp_step = 1'b1;
                if (iter_cnt == CALC_LAST) state_next = WR_ACC;
            end
            WR_ACC:  if (wr_gnt) state_next = WR_B;
            WR_B:    if (wr_gnt) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, iteration counter, captured op and OV flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
            op_q     <= OP_MUL;
            ov       <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                iter_cnt <= '0;
                op_q     <= op;
                // Divide-by-zero goes straight to DONE, so its flag is set now
                if (div_zero) ov <= 1'b1;
            end else if (state == CALC) begin
                iter_cnt <= iter_cnt + 3'd1;
            end
            // Flag result becomes visible together with the done pulse
            if (state == WR_B && wr_gnt) begin
                ov <= (op_q == OP_MUL) ? (product[15:8] != 8'h00) : 1'b0;
            end
        end
    end

    // Status and SFR write port outputs decoded from the current state
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        wr_en    = 1'b0;
        addr     = 8'h00;
        data_out = 8'h00;
        case (state)
            WR_ACC: begin
                wr_en    = 1'b1;
                addr     = ACC_ADDR;
                data_out = (op_q == OP_MUL) ? product[7:0] : quotient;
            end
            WR_B: begin
                wr_en    = 1'b1;
                addr     = B_ADDR;
                data_out = (op_q == OP_MUL) ? product[15:8] : remainder;
            end
            default: ;
        endcase
    end

    assign wr_bit_en = 1'b0;
    assign cy        = 1'b0;

    muldiv_dp u_dp (
        .clock     (clock),
        .reset     (reset),
        .start     (dp_start),
        .step      (dp_step),
        .op        (dp_op),
        .a_in      (acc_in),
        .b_in      (b_in),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes expected SFR writes and
// done events; a monitor pops and compares them as the DUT presents them.
module tb_muldiv_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] acc_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       wr_gnt = 1'b1;
    logic       busy, done, wr_en, wr_bit_en, ov, cy;
    logic [7:0] addr, data_out;

    typedef struct {
        bit         is_done;
        logic [7:0] addr;
        logic [7:0] data;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    muldiv_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .acc_in    (acc_in),
        .b_in      (b_in),
        .wr_gnt    (wr_gnt),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .wr_bit_en (wr_bit_en),
        .addr      (addr),
        .data_out  (data_out),
        .ov        (ov),
        .cy        (cy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected by scoreboard", name);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head
    always @(negedge clock) begin
        if (reset) begin
            if (wr_en) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    fail_event("unexpected_write");
                end else begin
                    check("wr_addr", {8'h00, addr}, {8'h00, sb[0].addr});
                    check("wr_data", {8'h00, data_out}, {8'h00, sb[0].data});
                    check("wr_bit_en", {15'h0, wr_bit_en}, 16'h0);
                    if (wr_gnt) void'(sb.pop_front());
                end
            end
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    fail_event("unexpected_done");
                end else begin
                    check("done_ov", {15'h0, ov}, {15'h0, sb[0].ov});
                    check("done_cy", {15'h0, cy}, 16'h0);
                    check("done_busy", {15'h0, busy}, 16'h1);
                    check("done_latency", 16'(cyc - start_cyc + 1), 16'(sb[0].lat));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic push_write(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.ov = 1'b0; e.lat = 0;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic o, input int lat);
        exp_t e;
        e.is_done = 1'b1; e.addr = 8'h00; e.data = 8'h00; e.ov = o; e.lat = lat;
        sb.push_back(e);
    endtask

    // One full operation; stall = WR_ACC cycles with wr_gnt low,
    // poke_done = raise start during the DONE cycle (must be ignored)
    task automatic do_op(input logic o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e_acc, input logic [7:0] e_b,
                         input logic e_ov, input int e_lat,
                         input int stall, input bit poke_done);
        bit dbz;
        bit seen;
        int k;
        dbz = (o == 1'b1) && (b == 8'h00);
        if (!dbz) begin
            push_write(8'hE0, e_acc);
            push_write(8'hF0, e_b);
        end
        push_done(e_ov, e_lat);
        @(negedge clock);
        op = o; acc_in = a; b_in = b; start = 1'b1;
        if (stall > 0) wr_gnt = 1'b0;
        start_cyc = cyc + 1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 60) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            acc_in = 8'hA5; b_in = 8'h5A;
            // Request while calculating must be ignored
            if (k == 1 && !dbz) begin
                start = 1'b1; op = ~o;
            end
            if (stall > 0 && k == 9 + stall) wr_gnt = 1'b1;
            if (done) begin
                seen = 1'b1;
                if (poke_done) begin
                    start = 1'b1; op = 1'b0; acc_in = 8'h33; b_in = 8'h44;
                end
            end
        end
        if (!seen) fail_event("done_timeout");
        @(negedge clock);
        start = 1'b0; wr_gnt = 1'b1;
        check("idle_after_done", {15'h0, busy}, 16'h0);
        check("done_one_cycle", {15'h0, done}, 16'h0);
        repeat (2) @(negedge clock);
        check("ov_hold", {15'h0, ov}, {15'h0, e_ov});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {15'h0, busy}, 16'h0);
        check({tag, "_done"}, {15'h0, done}, 16'h0);
        check({tag, "_wr_en"}, {15'h0, wr_en}, 16'h0);
        check({tag, "_wr_bit_en"}, {15'h0, wr_bit_en}, 16'h0);
        check({tag, "_addr"}, {8'h00, addr}, 16'h0);
        check({tag, "_data"}, {8'h00, data_out}, 16'h0);
        check({tag, "_ov"}, {15'h0, ov}, 16'h0);
        check({tag, "_cy"}, {15'h0, cy}, 16'h0);
    endtask

    // Start an operation and pull reset during cycle 5 of CALC
    task automatic abort_op(input logic o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        op = o; acc_in = a; b_in = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("abort_busy_before", {15'h0, busy}, 16'h1);
        #2 reset = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("abort_stays_idle", {15'h0, busy}, 16'h0);
    endtask

    initial begin
        #3 check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        // op, a, b, exp ACC, exp B, exp ov, latency, stall, poke in DONE
        do_op(1'b0, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0, 11, 0, 1'b1);
        do_op(1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 11, 0, 1'b0);
        abort_op(1'b0, 8'h0C, 8'h0D);
        do_op(1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 11, 0, 1'b0);
        do_op(1'b1, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 1, 0, 1'b1);
        do_op(1'b0, 8'h10, 8'h20, 8'h00, 8'h02, 1'b1, 14, 3, 1'b0);
        do_op(1'b1, 8'h07, 8'h09, 8'h00, 8'h07, 1'b0, 11, 0, 1'b0);
        do_op(1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 11, 0, 1'b0);
        repeat (3) @(negedge clock);
        check("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
